// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and index width
//   ZERO_REG                        : index of the hardwired-zero register
//   reg_idx_t                       : register index at the default index width
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned ZERO_REG       = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// population count of those bits.
// Ports:
//   clk, rst  : clock; synchronous active-low reset
//   wr_en     : per-port accepted write (already qualified for nonzero address)
//   wr_addr   : per-port write index, packed
//   iss_en    : mark iss_addr as pending
//   iss_addr  : destination being marked
//   flush     : clear every busy bit (issue in the same cycle still applies)
//   busy      : registered busy vector, bit 0 always 0
//   busy_cnt  : registered count of set busy bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned WR_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [2**ADDR_W-1:0]       busy,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int Depth = 2**ADDR_W;
  localparam int CntW  = ADDR_W + 1;

  logic [Depth-1:0] busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Priority, lowest to highest: hold, flush, write clear, issue set.
  // An issue landing on a register being written marks a newer producer.
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    for (int p = 0; p < int'(WR_PORTS); p++) begin
      if (wr_en[p]) begin
        busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (iss_en && (iss_addr != ADDR_W'(ZERO_REG))) begin
      busy_d[iss_addr] = 1'b1;
    end

    cnt_d = '0;
    for (int i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port general-purpose register file with pending-write scoreboard.
// Register 0 reads as zero; writes and issues to it are dropped.
// Ports:
//   clk, rst : clock; synchronous active-low reset (clears array and scoreboard)
//   rd_addr  : RD_PORTS packed read indices
//   rd_data  : RD_PORTS packed read values, combinational
//   rd_busy  : per read port, indexed register has a pending producer
//   wr_en    : per write port strobe
//   wr_addr  : WR_PORTS packed write indices
//   wr_data  : WR_PORTS packed write values
//   iss_en   : mark iss_addr pending
//   iss_addr : destination being marked
//   flush    : clear all pending bits, contents untouched
//   busy_cnt : number of pending registers (registered)
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// matching read ports and drop their busy indication.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int Depth = 2**ADDR_W;

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [Depth-1:0]    busy;
  logic [WR_PORTS-1:0] wr_acc;

  // A write is accepted only when it targets a real register.
  always_comb begin
    wr_acc = '0;
    for (int p = 0; p < int'(WR_PORTS); p++) begin
      wr_acc[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG));
    end
  end

  // Ports are applied in ascending order so the highest port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(WR_PORTS); p++) begin
        if (wr_acc[p]) begin
          mem_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .WR_PORTS (WR_PORTS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_acc),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = (ra == ADDR_W'(ZERO_REG)) ? '0 : mem_q[ra];
      bsy  = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // wr_acc excludes register 0, so a bypass never targets it.
      for (int p = 0; p < int'(WR_PORTS); p++) begin
        if (wr_acc[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
          data = wr_data[p*DATA_W +: DATA_W];
          // Issue is not forwarded: only an already-busy register that is
          // re-issued this cycle keeps reporting busy.
          bsy  = busy[ra] && iss_en && (iss_addr == ra);
        end
      end
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  register_file_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .RD_PORTS (NR),
    .WR_PORTS (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the architectural state as plain arrays.
  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];
  int unsigned   n_chk = 0;
  int unsigned   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic void m_read(input int k, output logic [31:0] d, output bit b);
    reg_idx_t a;
    a = rd_addr[k*AW +: AW];
    d = (a == 0) ? 32'h0 : m_mem[a];
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++) begin
      reg_idx_t wa;
      wa = wr_addr[p*AW +: AW];
      if (wr_en[p] && wa != 0 && wa == a) begin
        d = wr_data[p*DW +: DW];
        b = m_busy[a] && iss_en && (iss_addr == a);
      end
    end
`endif
  endfunction

  function automatic void m_edge();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      for (int p = 0; p < NW; p++) begin
        reg_idx_t wa;
        wa = wr_addr[p*AW +: AW];
        if (wr_en[p] && wa != 0) begin
          m_mem[wa]  = wr_data[p*DW +: DW];
          m_busy[wa] = 1'b0;
        end
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endfunction

  task automatic compare_all();
    logic [31:0] d;
    bit          b;
    for (int k = 0; k < NR; k++) begin
      m_read(k, d, b);
      check($sformatf("rd_data%0d(r%0d)", k, rd_addr[k*AW +: AW]), rd_data[k*DW +: DW], d);
      check($sformatf("rd_busy%0d(r%0d)", k, rd_addr[k*AW +: AW]), 32'(rd_busy[k]), 32'(b));
    end
    check("busy_cnt", 32'(busy_cnt), 32'(m_count()));
  endtask

  // One cycle: compare mid-cycle, advance model at the edge, drop strobes.
  task automatic step(input bit chk);
    @(negedge clk);
    if (chk) compare_all();
    @(posedge clk);
    m_edge();
    #1;
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    step(0);
    step(0);
    rst = 1'b1;
    step(1);

    // Reset discards written data and pending state.
    wr(0, 5, 32'hDEADBEEF);
    iss(3);
    rd(0, 5);
    step(1);
    rst = 1'b0;
    step(1);
    step(1);
    rst = 1'b1;
    rd(0, 5); rd(1, 3);
    #1;
    check("rst_r5_data", rd_data[31:0], 32'h0);
    check("rst_r3_busy", 32'(rd_busy[1]), 32'h0);
    check("rst_cnt", 32'(busy_cnt), 32'h0);

    // Same-address dual write: port 1 wins; r0 stays zero.
    wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    step(1);
    wr(0, 0, 32'hFFFF_FFFF);
    step(1);
    rd(0, 7); rd(1, 0);
    #1;
    check("dual_r7", rd_data[31:0], 32'h22);
    check("r0_zero", rd_data[63:32], 32'h0);

    // Scoreboard set, clear, and issue-beats-write.
    iss(9); rd(0, 9);
    step(1);
    check("iss_r9_busy", 32'(rd_busy[0]), 32'h1);
    check("iss_r9_cnt", 32'(busy_cnt), 32'h1);
    wr(0, 9, 32'h99);
    step(1);
    check("wr_r9_busy", 32'(rd_busy[0]), 32'h0);
    check("wr_r9_cnt", 32'(busy_cnt), 32'h0);
    iss(9); wr(1, 9, 32'h98);
    step(1);
    check("iss_wr_r9_busy", 32'(rd_busy[0]), 32'h1);
    wr(0, 9, 32'h97);
    step(1);

    // Flush with a simultaneous issue.
    iss(1); step(1);
    iss(2); step(1);
    iss(3); step(1);
    check("pre_flush_cnt", 32'(busy_cnt), 32'h3);
    flush = 1'b1; iss(4);
    rd(0, 4); rd(1, 1);
    step(1);
    check("flush_r4_busy", 32'(rd_busy[0]), 32'h1);
    check("flush_r1_busy", 32'(rd_busy[1]), 32'h0);
    check("flush_cnt", 32'(busy_cnt), 32'h1);

    // Same-cycle write while reading a busy register.
    iss(12); rd(0, 12);
    step(1);
    wr(0, 12, 32'hCAFE_0001);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_r12_data", rd_data[31:0], 32'hCAFE_0001);
    check("byp_r12_busy", 32'(rd_busy[0]), 32'h0);
`else
    check("nobyp_r12_data", rd_data[31:0], 32'h0);
    check("nobyp_r12_busy", 32'(rd_busy[0]), 32'h1);
`endif
    step(1);
    check("r12_next_data", rd_data[31:0], 32'hCAFE_0001);
    check("r12_next_busy", 32'(rd_busy[0]), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      for (int p = 0; p < NW; p++) begin
        int a;
        a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
        if ($urandom_range(0, 1) != 0) wr(p, a, $urandom);
      end
      if ($urandom_range(0, 3) == 0) iss(int'($urandom_range(0, 15)));
      flush = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 2) == 0 && wr_en[k % NW])
          rd(k, int'(wr_addr[(k % NW)*AW +: AW]));
        else
          rd(k, int'($urandom_range(0, 15)));
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port general-purpose register file for the MIPS core, successor to the single-write, two-read register file. Provides `RD_PORTS` combinational read ports, `WR_PORTS` write ports and a per-register pending-write scoreboard, so the decode stage can detect RAW hazards against in-flight producers. Optional write-to-read bypass lets a value written this cycle be read in the same cycle. Sits between decode (reads, issue marking) and writeback (writes).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register index width; depth = 2**ADDR_W
- `RD_PORTS`, 2, number of read ports (1..4)
- `WR_PORTS`, 2, number of write ports (1..2)

- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset; synchronous, active-low (state cleared on rising edge of `clk` while `rst`==0)
- `rd_addr`  input  RD_PORTS*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W]
- `rd_data`  output  RD_PORTS*DATA_W  read values, combinational
- `rd_busy`  output  RD_PORTS  1 = indexed register has a pending producer
- `wr_en`  input  WR_PORTS  per-port write strobe
- `wr_addr`  input  WR_PORTS*ADDR_W  write indices
- `wr_data`  input  WR_PORTS*DATA_W  write values
- `iss_en`  input  1  mark `iss_addr` as pending (instruction issued with destination)
- `iss_addr`  input  ADDR_W  destination being marked
- `flush`  input  1  clear every pending bit (pipeline flush); register contents untouched
- `busy_cnt`  output  ADDR_W+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_W x DATA_W array; register 0 is hardwired to zero. Reads of index 0 return 0; writes and issues to index 0 are ignored, and its busy bit is never set.
- Write: on the rising edge, each port with `wr_en`=1 and a nonzero address updates its register. If both write ports hit the same address, port WR_PORTS-1 wins.
- Scoreboard: one busy bit per register.
  - `iss_en` sets `busy[iss_addr]`.
  - Any accepted write clears `busy[wr_addr]`.
  - If a write and an issue hit the same register in the same cycle, the issue wins and the bit stays set: the new producer supersedes the old one.
  - `flush` clears all bits; an `iss_en` in the same cycle is still applied after the clear.
  - A single bit per register is deliberate. A second issue to an already-busy register is legal and is cleared by the next write.
- `busy_cnt`: a registered population count of the busy bits, updated every edge alongside them. Its maximum is 2**ADDR_W-1.
- Reset (`rst`==0 at an edge):
  - All registers are set to 0, all busy bits to 0, and `busy_cnt` to 0.
  - Reset overrides writes, issues and flush in that cycle.
  - Reset taken mid-operation discards all pending state.
- Reset values of outputs: `rd_data`=0 on all ports, `rd_busy`=0, `busy_cnt`=0.

## Timing
- Read: combinational from `rd_addr` to `rd_data`/`rd_busy`; zero cycles of latency.
- Write: committed at the edge; visible on `rd_data` from the next cycle (without bypass).
- Issue: `rd_busy` asserts in the cycle after `iss_en`.
- Write clearing busy: `rd_busy` drops the cycle after the write (without bypass).
- `busy_cnt` tracks the busy bits with the same one-edge latency.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - A read port whose address matches an active write port this cycle (nonzero address) returns that port's `wr_data` combinationally. The highest-index write port wins.
  - `rd_busy` for that port is forced to 0 in the same cycle, unless the register already holds an older busy state and `iss_en` targets it this cycle; issue does not bypass.
- Not defined: reads return only the stored array contents, and `rd_busy` reflects only the registered busy bits. Writeback-to-decode timing is then one cycle longer.

## Structure
- Shared package `regfile_pkg` holds:
  - `ZERO_REG` = 0
  - default `DATA_W`/`ADDR_W` localparams
  - a `reg_idx_t` typedef, ADDR_W bits wide
- One sub-module, `regfile_scoreboard`, holds the busy bits, the set/clear/flush priority and the `busy_cnt` counter. The array, write arbitration and bypass muxing stay in the top.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles after writing 0xDEADBEEF to r5. Release, then read r5 -> 0, `rd_busy`=0, `busy_cnt`=0.
- **Dual write, same address:** port0 writes r7=0x11, port1 writes r7=0x22 in the same cycle. Next cycle r7 reads 0x22. A write to r0 of 0xFFFF_FFFF reads back 0.
- **Scoreboard:**
  - `iss_en` r9 -> `rd_busy`=1 and `busy_cnt`=1 next cycle.
  - A write to r9 -> busy=0 and `busy_cnt`=0 the cycle after.
  - Issue r9 and write r9 in the same cycle -> busy remains 1.
- **Flush:** issue r1, r2, r3 on consecutive cycles (`busy_cnt`=3). Assert `flush` together with `iss_en` r4 -> next cycle only r4 is busy and `busy_cnt`=1.
- **Bypass (`REGFILE_BYPASS_EN`):**
  - With r12 busy, write r12=0xCAFE_0001 while reading r12 -> same-cycle `rd_data`=0xCAFE_0001 and `rd_busy`=0.
  - Without the macro -> old value and busy=1 that cycle; new value the next cycle.
